// File: rtl/alu_disp_pkg.sv
// Shared types and seven-segment constants for the ALU scan display.
package alu_disp_pkg;

    typedef enum logic {
        OPERANDS = 1'b0,
        RESULT   = 1'b1
    } state_t;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit6 = a ... bit0 = g; entry 15 listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/alu_scan_display_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level counter, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync_b;
                cnt   <= '0;
                pulse <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_scan_display.sv
// Operand capture, ADD/SUB with frozen flags, and multiplexed hex display.
module alu_scan_display
    import alu_disp_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  Data1,
    input  logic [WIDTH-1:0]  Data2,
    input  logic              Button_left,
    input  logic              Button_right,
    input  logic              Button_op,
    output logic [DIGITS-1:0] seg,
    output logic [6:0]        a_to_g,
    output logic              CF,
    output logic              OF
);

    localparam int unsigned NIB    = WIDTH / 4;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

    logic left_pulse;
    logic right_pulse;
    logic op_pulse;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk  (CLK),
        .rst  (RST),
        .btn  (Button_left),
        .pulse(left_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk  (CLK),
        .rst  (RST),
        .btn  (Button_right),
        .pulse(right_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_op (
        .clk  (CLK),
        .rst  (RST),
        .btn  (Button_op),
        .pulse(op_pulse)
    );

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] res;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] cap_res;
    logic             cap_cf;
    logic             cap_of;

    assign sum_ext  = {1'b0, Data1} + {1'b0, Data2};
    assign diff_ext = {1'b0, Data1} - {1'b0, Data2};

    // Candidate result and flags for a capture this cycle.
    always_comb begin
        cap_res = sum_ext[WIDTH-1:0];
        cap_cf  = sum_ext[WIDTH];
        cap_of  = (Data1[WIDTH-1] == Data2[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != Data1[WIDTH-1]);
        if (op == SUB) begin
            cap_res = diff_ext[WIDTH-1:0];
            cap_cf  = diff_ext[WIDTH];
            cap_of  = (Data1[WIDTH-1] != Data2[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != Data1[WIDTH-1]);
        end
    end

    // View FSM; left wins over a simultaneous right so no capture happens.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= OPERANDS;
            op    <= ADD;
            res   <= '0;
            CF    <= 1'b0;
            OF    <= 1'b0;
        end else begin
            if (op_pulse) begin
                op <= (op == ADD) ? SUB : ADD;
            end
            if (left_pulse) begin
                state <= OPERANDS;
                CF    <= 1'b0;
                OF    <= 1'b0;
            end else if (right_pulse) begin
                state <= RESULT;
                res   <= cap_res;
                CF    <= cap_cf;
                OF    <= cap_of;
            end
        end
    end

    logic [IDX_W-1:0]  digit_idx;
    logic [SCAN_W-1:0] scan_cnt;
    logic [31:0]       didx;
    logic [6:0]        digit_seg;

    assign didx = 32'(digit_idx);

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        digit_seg = SEG_BLANK;
        if (state == OPERANDS) begin
            if (didx < NIB) begin
                digit_seg = hex_to_seg(4'(Data2 >> (4 * didx)));
            end else if (didx < 2 * NIB) begin
                digit_seg = hex_to_seg(4'(Data1 >> (4 * (didx - NIB))));
            end
        end else if (didx < NIB) begin
            digit_seg = hex_to_seg(4'(res >> (4 * didx)));
        end
    end

    // Enable and segments load from the same index, so they never disagree.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            seg       <= '1;
            a_to_g    <= SEG_BLANK;
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            seg    <= ~(DIGITS'(1) << digit_idx);
            a_to_g <= digit_seg;
        end
    end

endmodule

// File: doc/alu_scan_display.md
Name: alu_scan_display

Overview:
- Parametrised successor to the 4-bit adder/display top.
- Captures two WIDTH-bit switch operands and computes ADD or SUB into a registered, frozen result with flags.
- Debounces three push-buttons and drives a DIGITS-wide multiplexed seven-segment display.
- Sits directly under the board top; replaces the combinational button latch, mux and display path.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of 4.
- DIGITS, 4, number of display digits; must be >= 2*(WIDTH/4).
- SCAN_DIV, 100000, CLK cycles each digit stays enabled.
- DEB_CYCLES, 1000000, CLK cycles a synchronised button level must be stable before it is accepted.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- Data1  in  WIDTH  operand A (switches, asynchronous).
- Data2  in  WIDTH  operand B (switches, asynchronous).
- Button_left  in  1  raw button; selects operand view.
- Button_right  in  1  raw button; captures operands and selects result view.
- Button_op  in  1  raw button; toggles ADD/SUB.
- seg  out  DIGITS  digit enables, active-low, one-hot-low.
- a_to_g  out  7  segments, active-low; bit6=a … bit0=g.
- CF  out  1  carry (ADD) or borrow (SUB) of the captured result.
- OF  out  1  signed overflow of the captured result.

Behaviour:
- Reset:
  - seg = all 1s; a_to_g = 7'h7F; CF = OF = 0.
  - State = OPERANDS; op = ADD; result register = 0; scan counter = 0; digit index = 0.
  - Debouncers hold accepted level 0 and stable counter 0.
  - The first cycle after RST falls drives digit 0.
- Buttons: each passes through a 2-flop synchroniser, then a stable counter.
  - The accepted level changes only after DEB_CYCLES consecutive cycles differing from it.
  - A 0->1 accepted transition produces exactly one 1-cycle pulse.
- FSM states: OPERANDS, RESULT.
  - Left pulse -> OPERANDS.
  - Right pulse -> RESULT, with capture.
  - Left and right pulses in the same cycle -> OPERANDS, no capture.
  - A right pulse while already in RESULT recaptures.
- Op: an op pulse toggles ADD/SUB in either state. It never changes an already captured result; it takes effect at the next capture.
- Capture (cycle of the right pulse):
  - res <= A+B or A-B, truncated to WIDTH bits.
  - ADD: CF = carry out.
  - SUB: CF = 1 iff A < B unsigned (borrow).
  - OF = two's-complement overflow.
  - res, CF and OF are visible from the next cycle and frozen until the next capture or RST.
- CF and OF are driven 0 in OPERANDS and show the captured flags in RESULT.
- Display content (N = WIDTH/4):
  - OPERANDS: digits 0..N-1 show live Data2 in hex; digits N..2N-1 show live Data1; remaining digits blank.
  - RESULT: digits 0..N-1 show res; remaining digits blank.
  - Blank means the digit is enabled with a_to_g = 7'h7F.
- Scan:
  - The counter counts 0..SCAN_DIV-1; on wrap the digit index increments, wrapping from DIGITS-1 to 0.
  - seg and a_to_g are registered and change together, one cycle after the index changes.
  - No ghosting: segments are never driven for the wrong digit.
- RST asserted mid-debounce, mid-scan or in RESULT returns every element to its reset values on the next edge.

Decomposition:
- Shared package alu_disp_pkg holds:
  - the state enum {OPERANDS, RESULT} and the op enum {ADD, SUB};
  - the hex-to-segment constant table (16 entries, active-low) and SEG_BLANK = 7'h7F.
- One sub-module: btn_debounce (synchroniser + stable counter + rising-edge pulse), parameter DEB_CYCLES, instantiated three times.

Test Plan:
Bench parameters: WIDTH=4, DIGITS=4, SCAN_DIV=4, DEB_CYCLES=3.
- Reset: RST=1 for 2 cycles -> seg=4'b1111, a_to_g=7'h7F, CF=OF=0. One cycle after release: seg=4'b1110, digit 0 shows Data2.
- Operand view: Data1=A, Data2=3 -> digit0 a_to_g=7'b0000110 ('3'), digit1 =7'b0001000 ('A'), digits 2 and 3 =7'h7F. Each digit enable lasts 4 cycles, in order 1110,1101,1011,0111, then wraps.
- ADD: Data1=9, Data2=8, right held for 5 cycles -> single capture; digit0 shows '1', CF=1, OF=1. Then change Data1=0 -> display and flags unchanged.
- SUB: op pulse, Data1=3, Data2=5, right pulse -> result E, CF=1, OF=0. Left pulse -> CF=OF=0 and operand view returns.
- Bounce: Button_right high for 2 cycles, low, high for 2 cycles -> no pulse, state stays OPERANDS.
- Simultaneous: left and right rising edges aligned -> state OPERANDS, result register unchanged. RST asserted in RESULT -> reset values on the next edge.
